// File: rtl/cdb_broadcaster_if.sv
// Bundle for the cdb_broadcaster: functional-unit result inputs with their
// ready back-pressure, plus the two-slot common data bus output.
//
// Handshake: a result on unit i transfers at a rising clock edge exactly when
// fu_valid[i] and fu_ready[i] are both high. fu_ready depends only on
// registered state, so a unit may test it early in the cycle. The CDB side has
// no ready: consumers must accept every valid slot in the cycle it appears.
//
// The master modport is the environment (units and CDB consumers). The slave
// modport is the broadcaster.
interface cdb_broadcaster_if #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 5
);
    logic [NUM_FU-1:0]            fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0] fu_tag;
    logic [NUM_FU-1:0][31:0]      fu_value;
    logic [NUM_FU-1:0][31:0]      fu_npc;
    logic [NUM_FU-1:0]            fu_take_branch;
    logic [NUM_FU-1:0]            fu_illegal;
    logic [NUM_FU-1:0]            fu_halt;
    logic [NUM_FU-1:0]            fu_ready;

    logic [1:0]                   cdb_valid;
    logic [1:0][TAG_W-1:0]        cdb_tag;
    logic [1:0][31:0]             cdb_value;
    logic [1:0][31:0]             cdb_npc;
    logic [1:0]                   cdb_take_branch;
    logic [1:0]                   cdb_illegal;
    logic [1:0]                   cdb_halt;

    modport master (
        output fu_valid, fu_tag, fu_value, fu_npc, fu_take_branch, fu_illegal, fu_halt,
        input  fu_ready,
        input  cdb_valid, cdb_tag, cdb_value, cdb_npc, cdb_take_branch, cdb_illegal, cdb_halt
    );

    modport slave (
        input  fu_valid, fu_tag, fu_value, fu_npc, fu_take_branch, fu_illegal, fu_halt,
        output fu_ready,
        output cdb_valid, cdb_tag, cdb_value, cdb_npc, cdb_take_branch, cdb_illegal, cdb_halt
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: buffers completed results from NUM_FU functional units in
// per-unit FIFOs and broadcasts up to two of them per cycle on the CDB, picked
// by a round-robin arbiter. Outputs are registered; invalid slots read as zero.
// Optional build macro CDB_PERF_EN adds perf_bcast_cnt / perf_stall_cnt.
module cdb_broadcaster #(
    parameter int NUM_FU     = 4,
    parameter int CDB_SIZE   = 2,
    parameter int TAG_W      = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    cdb_broadcaster_if.slave   bus
`ifdef CDB_PERF_EN
    ,
    output logic [31:0]        perf_bcast_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_FU  = IDX_W'(NUM_FU - 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      value;
        logic [31:0]      npc;
        logic             take_branch;
        logic             illegal;
        logic             halt;
    } payload_t;

    payload_t          mem    [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr [NUM_FU];
    logic [PTR_W-1:0]  wr_ptr [NUM_FU];
    logic [CNT_W-1:0]  count  [NUM_FU];
    logic [IDX_W-1:0]  rr_ptr;

    payload_t          in_pl  [NUM_FU];
    payload_t          head   [NUM_FU];
    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] gnt;

    logic              g0_valid;
    logic              g1_valid;
    logic [IDX_W-1:0]  g0_idx;
    logic [IDX_W-1:0]  g1_idx;
    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  rr_next;

    logic [CDB_SIZE-1:0] cdb_valid_q;
    payload_t            cdb_q [CDB_SIZE];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Per-unit FIFO status, head payload and accepted-push decode.
    always_comb begin
        ready = '0;
        req   = '0;
        push  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            ready[i] = (count[i] < DEPTH_C);
            req[i]   = (count[i] != '0);
            push[i]  = bus.fu_valid[i] && ready[i];
            in_pl[i] = '{tag:         bus.fu_tag[i],
                         value:       bus.fu_value[i],
                         npc:         bus.fu_npc[i],
                         take_branch: bus.fu_take_branch[i],
                         illegal:     bus.fu_illegal[i],
                         halt:        bus.fu_halt[i]};
            head[i]  = mem[i][rd_ptr[i]];
        end
    end

    // Round-robin pick of up to two distinct requesters starting at rr_ptr.
    always_comb begin
        g0_valid = 1'b0;
        g1_valid = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (req[(int'(rr_ptr) + k) % NUM_FU]) begin
                if (!g0_valid) begin
                    g0_valid = 1'b1;
                    g0_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_FU);
                end else if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_FU);
                end
            end
        end
    end

    // Grant vector and the pointer value following the last granted unit.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            gnt[i] = (g0_valid && (g0_idx == IDX_W'(i))) ||
                     (g1_valid && (g1_idx == IDX_W'(i)));
        end
        last_idx = g1_valid ? g1_idx : g0_idx;
        rr_next  = (last_idx == LAST_FU) ? '0 : last_idx + 1'b1;
    end

    // FIFO storage, pointers and occupancy; squash discards everything buffered.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            for (int i = 0; i < NUM_FU; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= in_pl[i];
                    wr_ptr[i]         <= ptr_inc(wr_ptr[i]);
                end
                if (gnt[i]) begin
                    rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                end
                case ({push[i], gnt[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Arbiter pointer and registered CDB slots; grants made during squash are dropped.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            rr_ptr      <= '0;
            cdb_valid_q <= '0;
            for (int s = 0; s < CDB_SIZE; s++) begin
                cdb_q[s] <= '0;
            end
        end else begin
            if (g0_valid) begin
                rr_ptr <= rr_next;
            end
            cdb_valid_q[0] <= g0_valid;
            cdb_valid_q[1] <= g1_valid;
            cdb_q[0]       <= g0_valid ? head[g0_idx] : '0;
            cdb_q[1]       <= g1_valid ? head[g1_idx] : '0;
        end
    end

    assign bus.fu_ready  = ready;
    assign bus.cdb_valid = cdb_valid_q;

    for (genvar s = 0; s < CDB_SIZE; s++) begin : g_slot
        assign bus.cdb_tag[s]         = cdb_q[s].tag;
        assign bus.cdb_value[s]       = cdb_q[s].value;
        assign bus.cdb_npc[s]         = cdb_q[s].npc;
        assign bus.cdb_take_branch[s] = cdb_q[s].take_branch;
        assign bus.cdb_illegal[s]     = cdb_q[s].illegal;
        assign bus.cdb_halt[s]        = cdb_q[s].halt;
    end

`ifdef CDB_PERF_EN
    logic [1:0] slots_now;

    // Number of CDB slots carrying a result this cycle.
    always_comb begin
        slots_now = {1'b0, cdb_valid_q[0]} + {1'b0, cdb_valid_q[1]};
    end

    // Broadcast and stall counters, cleared together with the buffers.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            perf_bcast_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_bcast_cnt <= perf_bcast_cnt + 32'(slots_now);
            if (|(req & ~gnt)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster. Results are queued per unit when
// driven; a monitor matches each CDB slot against the heads of those queues.
module tb_cdb_broadcaster;
    localparam int NUM_FU = 4;
    localparam int TAG_W  = 5;
    localparam int W      = TAG_W + 32 + 32 + 3;

    logic clock = 1'b0;
    logic reset;
    logic squash;

    always #5 clock = ~clock;

    cdb_broadcaster_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W)) bus ();

`ifdef CDB_PERF_EN
    logic [31:0] perf_bcast_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    cdb_broadcaster #(
        .NUM_FU(NUM_FU), .CDB_SIZE(2), .TAG_W(TAG_W), .FIFO_DEPTH(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .squash(squash),
        .bus(bus)
`ifdef CDB_PERF_EN
        ,
        .perf_bcast_cnt(perf_bcast_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q [NUM_FU][$];
    int grant_cnt [NUM_FU];
    logic count_en = 1'b0;
    int seq = 0;
    logic [W-1:0] mon_pkt;
    logic mon_found;
    logic [31:0] snap_a;
    logic [31:0] snap_b;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit queues_empty();
        for (int u = 0; u < NUM_FU; u++) begin
            if (exp_q[u].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Present a result on unit u without expecting it to be broadcast.
    task automatic drive_raw(input int u, input logic [TAG_W-1:0] tag, input logic [31:0] value,
                             output logic [W-1:0] pkt);
        logic [31:0] npc;
        logic tb_f, il_f, ht_f;
        npc  = $urandom;
        tb_f = 1'($urandom_range(0, 1));
        il_f = 1'($urandom_range(0, 1));
        ht_f = 1'($urandom_range(0, 1));
        bus.fu_valid[u]       = 1'b1;
        bus.fu_tag[u]         = tag;
        bus.fu_value[u]       = value;
        bus.fu_npc[u]         = npc;
        bus.fu_take_branch[u] = tb_f;
        bus.fu_illegal[u]     = il_f;
        bus.fu_halt[u]        = ht_f;
        pkt = {tag, value, npc, tb_f, il_f, ht_f};
    endtask

    // Present a result on unit u and queue it as an expected broadcast.
    task automatic drive_unit(input int u, input logic [TAG_W-1:0] tag, input logic [31:0] value);
        logic [W-1:0] pkt;
        drive_raw(u, tag, value, pkt);
        exp_q[u].push_back(pkt);
        seq++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        bus.fu_valid = '0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!queues_empty() && n < 40) begin
            tick();
            n++;
        end
        checks++;
        assert (queues_empty()) else begin
            errors++;
            $error("FAIL drain_timeout: observed results still pending after %0d cycles expected none", n);
        end
        tick();
        tick();
    endtask

    // Protocol: the bench never offers a result to a unit that is not ready.
    always @(posedge clock) begin
        if (reset === 1'b0) begin
            checks++;
            assert ((bus.fu_valid & ~bus.fu_ready) == '0) else begin
                errors++;
                $error("FAIL valid_without_ready: observed valid %b ready %b expected no overlap",
                       bus.fu_valid, bus.fu_ready);
            end
        end
    end

    // Monitor: every valid slot must be the oldest pending result of some unit.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            for (int s = 0; s < 2; s++) begin
                mon_pkt = {bus.cdb_tag[s], bus.cdb_value[s], bus.cdb_npc[s],
                           bus.cdb_take_branch[s], bus.cdb_illegal[s], bus.cdb_halt[s]};
                if (bus.cdb_valid[s] === 1'b1) begin
                    mon_found = 1'b0;
                    for (int u = 0; u < NUM_FU; u++) begin
                        if (!mon_found && exp_q[u].size() > 0 && exp_q[u][0] === mon_pkt) begin
                            mon_found = 1'b1;
                            void'(exp_q[u].pop_front());
                            if (count_en) grant_cnt[u]++;
                        end
                    end
                    checks++;
                    assert (mon_found) else begin
                        errors++;
                        $error("FAIL cdb_slot%0d_unexpected: observed packet %0h expected a pending head", s, mon_pkt);
                    end
                end else begin
                    chk($sformatf("cdb_slot%0d_idle_zero", s), mon_pkt, '0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion expected $finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset               = 1'b1;
        squash              = 1'b0;
        bus.fu_valid        = '0;
        bus.fu_tag          = '0;
        bus.fu_value        = '0;
        bus.fu_npc          = '0;
        bus.fu_take_branch  = '0;
        bus.fu_illegal      = '0;
        bus.fu_halt         = '0;
        for (int u = 0; u < NUM_FU; u++) grant_cnt[u] = 0;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state and idle.
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("idle_cdb_valid", bus.cdb_valid, 2'b00);
            chk("idle_fu_ready", bus.fu_ready, 4'b1111);
`ifdef CDB_PERF_EN
            chk("idle_perf_bcast", perf_bcast_cnt, 32'd0);
            chk("idle_perf_stall", perf_stall_cnt, 32'd0);
`endif
            tick();
        end

        // Single result from unit 2: visible two cycles later.
        drive_unit(2, 5'd5, 32'hDEAD);
        tick();
        @(negedge clock);
        chk("single_c1_valid", bus.cdb_valid, 2'b00);
        tick();
        @(negedge clock);
        chk("single_c2_valid", bus.cdb_valid, 2'b01);
        chk("single_c2_tag", bus.cdb_tag[0], 5'd5);
        chk("single_c2_value", bus.cdb_value[0], 32'hDEAD);
        chk("single_c2_slot1_tag", bus.cdb_tag[1], '0);
        chk("single_c2_slot1_value", bus.cdb_value[1], '0);
        chk("single_c2_slot1_npc", bus.cdb_npc[1], '0);
        chk("single_c2_slot1_flags",
            {bus.cdb_take_branch[1], bus.cdb_illegal[1], bus.cdb_halt[1]}, 3'b000);
        tick();

        // A lone unit-3 result moves the pointer from 3 round to 0.
        drive_unit(3, 5'd6, 32'hBEEF);
        wait_drain();

        // Four simultaneous results with the pointer at 0.
        for (int u = 0; u < NUM_FU; u++) drive_unit(u, 5'(u + 1), 32'h100 + 32'(u));
        tick();
        @(negedge clock);
        chk("four_c1_valid", bus.cdb_valid, 2'b00);
        tick();
        @(negedge clock);
        chk("four_c2_valid", bus.cdb_valid, 2'b11);
        chk("four_c2_tag0", bus.cdb_tag[0], 5'd1);
        chk("four_c2_tag1", bus.cdb_tag[1], 5'd2);
        tick();
        @(negedge clock);
        chk("four_c3_valid", bus.cdb_valid, 2'b11);
        chk("four_c3_tag0", bus.cdb_tag[0], 5'd3);
        chk("four_c3_tag1", bus.cdb_tag[1], 5'd4);
        tick();
        @(negedge clock);
        chk("four_c4_valid", bus.cdb_valid, 2'b00);
        tick();

        // Pointer back at 0: unit 0 must win slot 0 over unit 3.
        drive_unit(3, 5'd7, 32'h300);
        drive_unit(0, 5'd8, 32'h301);
        tick();
        tick();
        @(negedge clock);
        chk("rr0_valid", bus.cdb_valid, 2'b11);
        chk("rr0_slot0_tag", bus.cdb_tag[0], 5'd8);
        chk("rr0_slot1_tag", bus.cdb_tag[1], 5'd7);
        tick();
        wait_drain();

        // Unit 1 streams alongside unit 0 only: it drains every cycle.
        for (int c = 0; c < 8; c++) begin
            if (c < 6) begin
                drive_unit(0, 5'(seq), 32'h1000 + 32'(seq));
                drive_unit(1, 5'(seq), 32'h1000 + 32'(seq));
            end
            @(negedge clock);
            chk("stream_ready1", bus.fu_ready[1], 1'b1);
            tick();
        end
        wait_drain();

        // Pointer now at 2: units 2/3 win first, so unit 1 fills up.
        for (int u = 0; u < NUM_FU; u++) drive_unit(u, 5'(seq), 32'h2000 + 32'(seq));
        tick();
        drive_unit(1, 5'(seq), 32'h2000 + 32'(seq));
        drive_unit(2, 5'(seq), 32'h2000 + 32'(seq));
        drive_unit(3, 5'(seq), 32'h2000 + 32'(seq));
        @(negedge clock);
        chk("bp_y1_ready1", bus.fu_ready[1], 1'b1);
        tick();
        drive_unit(0, 5'(seq), 32'h2000 + 32'(seq));
        @(negedge clock);
        chk("bp_y2_ready1", bus.fu_ready[1], 1'b0);
        tick();
        @(negedge clock);
        chk("bp_y3_ready1", bus.fu_ready[1], 1'b1);
        tick();
        wait_drain();

        // Squash with five results buffered.
        for (int u = 0; u < NUM_FU; u++) drive_unit(u, 5'(seq), 32'h3000 + 32'(seq));
        tick();
        for (int u = 0; u < 3; u++) drive_unit(u, 5'(seq), 32'h3000 + 32'(seq));
        tick();
        squash = 1'b1;
        begin
            logic [W-1:0] ignored;
            drive_raw(3, 5'd31, 32'hBAD0BAD0, ignored);
        end
        @(negedge clock);
        chk("squash_s_valid", bus.cdb_valid, 2'b11);
        tick();
        squash = 1'b0;
        for (int u = 0; u < NUM_FU; u++) exp_q[u].delete();
        @(negedge clock);
        chk("squash_s1_valid", bus.cdb_valid, 2'b00);
        chk("squash_s1_ready", bus.fu_ready, 4'b1111);
`ifdef CDB_PERF_EN
        chk("squash_perf_bcast", perf_bcast_cnt, 32'd0);
        chk("squash_perf_stall", perf_stall_cnt, 32'd0);
`endif
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("squash_quiet_valid", bus.cdb_valid, 2'b00);
            tick();
        end

        // Fairness: every unit kept non-empty; count grants over 8 cycles.
        snap_a = '0;
        snap_b = '0;
        for (int c = 0; c < 14; c++) begin
            if (c == 2) count_en = 1'b1;
            if (c == 10) count_en = 1'b0;
            for (int u = 0; u < NUM_FU; u++) begin
                if (bus.fu_ready[u]) drive_unit(u, 5'(seq), 32'h4000 + 32'(seq));
            end
            @(negedge clock);
`ifdef CDB_PERF_EN
            if (c == 1) snap_a = perf_stall_cnt;
            if (c == 9) chk("fair_perf_stall", perf_stall_cnt - snap_a, 32'd8);
            if (c == 2) snap_b = perf_bcast_cnt;
            if (c == 10) chk("fair_perf_bcast", perf_bcast_cnt - snap_b, 32'd16);
`endif
            tick();
        end
        wait_drain();
        for (int u = 0; u < NUM_FU; u++) begin
            chk($sformatf("fair_grants_u%0d", u), grant_cnt[u], 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Completion-side transmitter for the common data bus. Collects finished results from `NUM_FU` functional units, buffers each unit's results in a small FIFO, and drives up to `CDB_SIZE` (2) CDB packets per cycle to the ROB, reservation stations and map table. A round-robin arbiter picks which units broadcast. Each unit gets back-pressure through a ready signal, so no result is dropped.

## Interface
Parameters:
- `NUM_FU`, 4: number of functional-unit request ports.
- `CDB_SIZE`, 2: CDB slots per cycle; fixed at 2.
- `TAG_W`, 5: ROB tag width, equal to $clog2(`ROB_SIZE) for a 32-entry ROB.
- `FIFO_DEPTH`, 2: entries per functional-unit FIFO.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `squash`  in  1  flush all buffered results.
- `fu_valid`  in  NUM_FU  unit i presents a result this cycle.
- `fu_tag`  in  NUM_FU x TAG_W  destination ROB tag.
- `fu_value`  in  NUM_FU x 32  result value.
- `fu_npc`  in  NUM_FU x 32  next PC.
- `fu_take_branch`  in  NUM_FU  branch taken.
- `fu_illegal`  in  NUM_FU  illegal instruction.
- `fu_halt`  in  NUM_FU  halt instruction.
- `fu_ready`  out  NUM_FU  unit i's FIFO can accept a result this cycle.
- `cdb_valid`  out  2  slot valid.
- `cdb_tag`  out  2 x TAG_W  tag per slot.
- `cdb_value`  out  2 x 32  value per slot.
- `cdb_npc`  out  2 x 32  next PC per slot.
- `cdb_take_branch`  out  2  branch taken per slot.
- `cdb_illegal`  out  2  illegal per slot.
- `cdb_halt`  out  2  halt per slot.

## Operation
- Each unit has its own FIFO of depth `FIFO_DEPTH` holding the payload {tag, value, npc, take_branch, illegal, halt}.
- Push:
  - A push happens when `fu_valid[i]` and `fu_ready[i]` are both high.
  - `fu_ready[i]` = (count_i < FIFO_DEPTH), computed from registered state only.
  - A pop in the same cycle does not raise `fu_ready`.
  - `fu_valid` while `fu_ready` is low is a protocol violation; the result is dropped. The bench asserts this never happens.
- Arbitration (combinational over FIFO heads):
  - Requesters are units with count > 0.
  - Slot 0 is granted to the first requester at or after rr_ptr, in circular order.
  - Slot 1 is granted to the next distinct requester after that.
  - A unit receives at most one grant per cycle.
  - With a single grant, the result goes on slot 0 and slot 1 is invalid.
- Pop: each granted unit pops its FIFO head at the clock edge. Simultaneous push and pop on one FIFO is legal; count is unchanged.
- rr_ptr update:
  - Next value is (index of last granted unit + 1) mod NUM_FU.
  - rr_ptr holds when there is no grant.
- CDB outputs are registered. Invalid slots drive all payload fields to 0.
- Tags are passed through unchanged. The block performs no tag-collision checks.

## Timing
- Reset values:
  - All `cdb_*` outputs are 0.
  - `fu_ready` is all-ones.
  - FIFOs are empty and rr_ptr = 0.
- Latency:
  - A result accepted in cycle N is at the FIFO head in cycle N+1.
  - If granted in N+1, it appears on the CDB in cycle N+2, for a minimum latency of 2 cycles.
- Throughput is at most 2 results per cycle total and at most 1 per unit per cycle.
- Full FIFO: `fu_ready[i]` drops the cycle after the second push. It rises the cycle after a pop, if no push occurred in that cycle.
- Squash, in cycle S:
  - All FIFOs clear and rr_ptr returns to 0 at the S edge.
  - `cdb_valid` = 0 in S+1.
  - `fu_valid` during S is ignored.
  - Arbitration results computed in S are discarded.
- `reset` has priority over `squash`. Either one asserted mid-operation discards all buffered results.
- Wrap-around: rr_ptr is mod NUM_FU. FIFO read and write pointers wrap mod FIFO_DEPTH.

## Configuration
- Macro: `CDB_PERF_EN`.
- When defined, the block adds two outputs:
  - `perf_bcast_cnt` (32 bits) increments by the number of valid CDB slots each cycle.
  - `perf_stall_cnt` (32 bits) increments by 1 each cycle in which any unit has count > 0 but is not granted.
  - Both counters clear on reset and on squash, and wrap mod 2^32.
- When undefined, neither output port nor counter logic exists. Functional behaviour is identical in both builds.

## Test plan
- Reset, then idle: `cdb_valid` = 2'b00, `fu_ready` = 4'b1111 every cycle.
- Single result: unit 2 sends tag 5, value 0xDEAD in cycle 0.
  - Required: cycle 2 shows `cdb_valid` = 2'b01, slot 0 tag 5, value 0xDEAD, slot 1 payload all zeros.
- Four simultaneous results: units 0-3 send tags 1-4 in cycle 0, with rr_ptr = 0.
  - Cycle 2: tags 1 and 2 on slots 0 and 1.
  - Cycle 3: tags 3 and 4.
  - rr_ptr = 0 afterwards.
- Back-pressure: unit 1 pushes every cycle while only unit 0 is also active.
  - `fu_ready[1]` never drops, because unit 1 drains at 1 per cycle.
  - Then block draining by holding units 0, 2 and 3 busy with rr_ptr favouring them: `fu_ready[1]` = 0 after two un-drained pushes, and no result is lost or reordered.
- Squash while FIFOs hold 5 results:
  - `cdb_valid` = 0 the next cycle, `fu_ready` = all-ones, and no stale tag is ever broadcast.
- Fairness: all 4 units continuously full for 8 cycles.
  - Each unit is granted exactly 4 times.
  - With `CDB_PERF_EN`, `perf_bcast_cnt` = 16.
